// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults, bank-state encoding and bit-reverse helper for the
// sample frame buffer and the FFT front end.
//   SFB_DATA_W / SFB_ADDR_W : default sample width / log2 frame length
//   BANK_*                  : per-bank ping-pong state encoding
//   bitrev(v, w)            : reverse the low w bits of v
package fft_pkg;

  localparam int unsigned SFB_DATA_W     = 16;
  localparam int unsigned SFB_ADDR_W     = 8;
  localparam int unsigned SFB_MAX_ADDR_W = 16;

  localparam logic [1:0] BANK_EMPTY   = 2'd0;
  localparam logic [1:0] BANK_FILLING = 2'd1;
  localparam logic [1:0] BANK_FULL    = 2'd2;
  localparam logic [1:0] BANK_READING = 2'd3;

  // Shift-based reversal keeps every select constant; result sits in the low w bits.
  function automatic logic [SFB_MAX_ADDR_W-1:0] bitrev(
    input logic [SFB_MAX_ADDR_W-1:0] v,
    input int unsigned               w
  );
    logic [SFB_MAX_ADDR_W-1:0] r;
    logic [SFB_MAX_ADDR_W-1:0] t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < SFB_MAX_ADDR_W; i++) begin
      if (i < w) begin
        r = {r[SFB_MAX_ADDR_W-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// sample_ram: simple dual-port RAM, one write port and one registered read port.
// The read register only loads when re=1, so it holds its word while stalled.
// Contents are never reset.
//   clk             : clock
//   we, waddr, wdata: write port
//   re, raddr       : read request, data appears on rdata the next cycle
//   rdata           : registered read data
module sample_ram #(
  parameter int unsigned DATA_W = fft_pkg::SFB_DATA_W,
  parameter int unsigned ADDR_W = fft_pkg::SFB_ADDR_W + 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sample_frame_buffer.sv
// sample_frame_buffer: ping-pong frame buffer between the ADC SPI stage and the
// FFT stage. Samples fill one bank of N=2^ADDR_W words while the other bank is
// streamed out with valid/ready handshaking.
//   CLK, RST_N          : clock, async active-low reset
//   DV, DATA_IN         : incoming sample strobe and data
//   OUT_VALID/OUT_READY : output handshake
//   OUT_DATA, OUT_INDEX : offered sample and its original in-frame index
//   OUT_LAST            : final sample of a frame
//   OVERFLOW            : sticky, a sample was dropped
// Build option: define SFB_BITREV_EN to emit frames in bit-reversed order.
module sample_frame_buffer #(
  parameter int unsigned DATA_W = fft_pkg::SFB_DATA_W,
  parameter int unsigned ADDR_W = fft_pkg::SFB_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              DV,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [ADDR_W-1:0] OUT_INDEX,
  output logic              OUT_LAST,
  output logic              OVERFLOW
);

  import fft_pkg::*;

  localparam int unsigned RAM_AW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_POS = '1;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_FETCH  = 2'd1;
  localparam logic [1:0] R_STREAM = 2'd2;

  // Frame position -> bank address (and reported index).
  function automatic logic [ADDR_W-1:0] pos_to_addr(input logic [ADDR_W-1:0] k);
`ifdef SFB_BITREV_EN
    return ADDR_W'(bitrev(SFB_MAX_ADDR_W'(k), ADDR_W));
`else
    return k;
`endif
  endfunction

  logic [1:0]            rstate_q,    rstate_d;
  logic [1:0][1:0]       bank_st_q,   bank_st_d;
  logic [ADDR_W-1:0]     wp_q,        wp_d;
  logic [ADDR_W-1:0]     rp_q,        rp_d;
  logic                  rd_done_q,   rd_done_d;
  logic                  rd_bank_q,   rd_bank_d;
  logic                  oldest_q,    oldest_d;
  logic                  ovf_q,       ovf_d;
  logic                  ram_vld_q,   ram_vld_d;
  logic [ADDR_W-1:0]     ram_k_q,     ram_k_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q,  out_data_d;
  logic [ADDR_W-1:0]     out_index_q, out_index_d;
  logic                  out_last_q,  out_last_d;

  logic                  any_fill;
  logic                  wbank;
  logic                  we;
  logic [RAM_AW-1:0]     waddr;
  logic                  full0;
  logic                  full1;
  logic                  sel_bank;
  logic                  start;
  logic                  load_out;
  logic                  xfer;
  logic                  frame_done;
  logic                  re;
  logic                  rbank;
  logic [RAM_AW-1:0]     raddr;
  logic [DATA_W-1:0]     ram_rdata;

  // Write side: only a FILLING bank accepts samples.
  always_comb begin
    any_fill = (bank_st_q[0] == BANK_FILLING) || (bank_st_q[1] == BANK_FILLING);
    wbank    = (bank_st_q[1] == BANK_FILLING);
    we       = DV && any_fill;
    waddr    = {wbank, wp_q};
  end

  // Read side: two-stage pipeline (RAM output register, then output register).
  // A new read is issued only when the RAM register is free or draining into
  // the output stage, so the RAM register doubles as the skid buffer.
  always_comb begin
    full0      = (bank_st_q[0] == BANK_FULL);
    full1      = (bank_st_q[1] == BANK_FULL);
    sel_bank   = (full0 && full1) ? oldest_q : full1;
    start      = (rstate_q == R_IDLE) && (full0 || full1);
    load_out   = ram_vld_q && (!out_valid_q || OUT_READY);
    xfer       = out_valid_q && OUT_READY;
    frame_done = xfer && out_last_q;
    re         = start ||
                 ((rstate_q != R_IDLE) && !rd_done_q && (!ram_vld_q || load_out));
    rbank      = start ? sel_bank : rd_bank_q;
    raddr      = {rbank, pos_to_addr(rp_q)};
  end

  // Next-state and output logic
  always_comb begin
    rstate_d    = rstate_q;
    bank_st_d   = bank_st_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    rd_done_d   = rd_done_q;
    rd_bank_d   = rd_bank_q;
    oldest_d    = oldest_q;
    ovf_d       = ovf_q;
    ram_vld_d   = ram_vld_q;
    ram_k_d     = ram_k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;

    // Read FSM
    case (rstate_q)
      R_IDLE: begin
        if (start) begin
          rstate_d             = R_FETCH;
          rd_bank_d            = sel_bank;
          rd_done_d            = 1'b0;
          bank_st_d[sel_bank]  = BANK_READING;
        end
      end
      R_FETCH: begin
        rstate_d = R_STREAM;
      end
      R_STREAM: begin
        if (frame_done) begin
          rstate_d             = R_IDLE;
          bank_st_d[rd_bank_q] = BANK_EMPTY;
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    // Read pointer; it wraps back to 0 after the last position.
    if (re) begin
      rp_d    = rp_q + ADDR_W'(1);
      ram_k_d = rp_q;
      if (rp_q == LAST_POS) rd_done_d = 1'b1;
    end

    if (re)            ram_vld_d = 1'b1;
    else if (load_out) ram_vld_d = 1'b0;

    // Output register
    if (load_out) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_rdata;
      out_index_d = pos_to_addr(ram_k_q);
      out_last_d  = (ram_k_q == LAST_POS);
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end

    // Write pointer and fill completion
    if (we) begin
      wp_d = wp_q + ADDR_W'(1);
      if (wp_q == LAST_POS) begin
        bank_st_d[wbank] = BANK_FULL;
        oldest_d         = (bank_st_q[~wbank] == BANK_FULL) ? ~wbank : wbank;
      end
    end
    if (DV && !any_fill) ovf_d = 1'b1;

    // With no bank FILLING, an EMPTY bank takes over immediately so it is
    // writable on the next cycle.
    if ((bank_st_d[0] != BANK_FILLING) && (bank_st_d[1] != BANK_FILLING)) begin
      if (bank_st_d[0] == BANK_EMPTY)      bank_st_d[0] = BANK_FILLING;
      else if (bank_st_d[1] == BANK_EMPTY) bank_st_d[1] = BANK_FILLING;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rstate_q    <= R_IDLE;
      bank_st_q   <= {BANK_EMPTY, BANK_FILLING};
      wp_q        <= '0;
      rp_q        <= '0;
      rd_done_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      oldest_q    <= 1'b0;
      ovf_q       <= 1'b0;
      ram_vld_q   <= 1'b0;
      ram_k_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      rstate_q    <= rstate_d;
      bank_st_q   <= bank_st_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      rd_done_q   <= rd_done_d;
      rd_bank_q   <= rd_bank_d;
      oldest_q    <= oldest_d;
      ovf_q       <= ovf_d;
      ram_vld_q   <= ram_vld_d;
      ram_k_q     <= ram_k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (RAM_AW)
  ) u_sample_ram (
    .clk   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (DATA_IN),
    .re    (re),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_INDEX = out_index_q;
  assign OUT_LAST  = out_last_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// tb_sample_frame_buffer: directed self-checking bench for sample_frame_buffer
// with N=8. Follows SFB_BITREV_EN to pick the expected output order.
module tb_sample_frame_buffer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  logic              CLK;
  logic              RST_N;
  logic              DV;
  logic [DATA_W-1:0] DATA_IN;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic [ADDR_W-1:0] OUT_INDEX;
  logic              OUT_LAST;
  logic              OVERFLOW;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_idx [8];

  sample_frame_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .DV        (DV),
    .DATA_IN   (DATA_IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_INDEX (OUT_INDEX),
    .OUT_LAST  (OUT_LAST),
    .OVERFLOW  (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; DV = 1'b0; DATA_IN = '0; OUT_READY = 1'b0;
    repeat (3) tick();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", OUT_VALID); end
    checks++; if (OUT_LAST !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", OUT_LAST); end
    checks++; if (OUT_DATA !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", OUT_DATA); end
    checks++; if (OUT_INDEX !== 3'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", OUT_INDEX); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", OVERFLOW); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    OUT_READY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      DV = 1'b1; DATA_IN = 16'(k);
      tick();
    end
    DV = 1'b0;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL basic_lat0: valid got %b want 0", OUT_VALID); end
    tick();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL basic_lat1: valid got %b want 0", OUT_VALID); end
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'(exp_idx[k]) || OUT_INDEX !== exp_idx[k] || OUT_LAST !== (k == 7)) begin
        errors++;
        $display("FAIL basic_word%0d: got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b",
                 k, OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, 16'(exp_idx[k]), exp_idx[k], (k == 7));
      end
      tick();
    end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL basic_after: valid got %b want 0", OUT_VALID); end
  endtask

  task automatic test_stall();
    int n;
    logic held;
    logic [15:0] sv_data;
    logic [2:0] sv_idx;
    logic sv_last;
    n = 0; held = 1'b0; sv_data = '0; sv_idx = '0; sv_last = 1'b0;
    OUT_READY = 1'b0;
    for (int k = 0; k < 8; k++) begin
      DV = 1'b1; DATA_IN = 16'h0020 + 16'(k);
      tick();
    end
    DV = 1'b0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      if (held) begin
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== sv_data || OUT_INDEX !== sv_idx || OUT_LAST !== sv_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b",
                   OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, sv_data, sv_idx, sv_last);
        end
      end
      held = 1'b0;
      if (OUT_VALID === 1'b1) begin
        if (OUT_READY) begin
          checks++;
          if (OUT_DATA !== 16'h0020 + 16'(exp_idx[n]) || OUT_INDEX !== exp_idx[n] || OUT_LAST !== (n == 7)) begin
            errors++;
            $display("FAIL stall_word%0d: got d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                     n, OUT_DATA, OUT_INDEX, OUT_LAST, 16'h0020 + 16'(exp_idx[n]), exp_idx[n], (n == 7));
          end
          n++;
        end else begin
          held = 1'b1; sv_data = OUT_DATA; sv_idx = OUT_INDEX; sv_last = OUT_LAST;
        end
      end
      tick();
      OUT_READY = ~OUT_READY;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL stall_count: got %0d transfers want 8", n); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL stall_nodup: valid got %b want 0", OUT_VALID); end
  endtask

  task automatic test_overflow();
    int n;
    int gap;
    logic [15:0] exp_d;
    n = 0; gap = 0;
    OUT_READY = 1'b0;
    for (int k = 0; k < 24; k++) begin
      DV = 1'b1; DATA_IN = 16'(k);
      tick();
      if (k == 15) begin
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b want 0", OVERFLOW); end
      end
      if (k == 16) begin
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", OVERFLOW); end
      end
    end
    DV = 1'b0;
    OUT_READY = 1'b1;
    for (int c = 0; c < 80 && n < 16; c++) begin
      if (OUT_VALID === 1'b1) begin
        exp_d = ((n < 8) ? 16'h0000 : 16'h0008) + 16'(exp_idx[n % 8]);
        checks++;
        if (OUT_DATA !== exp_d || OUT_INDEX !== exp_idx[n % 8] || OUT_LAST !== ((n % 8) == 7)) begin
          errors++;
          $display("FAIL ovf_word%0d: got d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                   n, OUT_DATA, OUT_INDEX, OUT_LAST, exp_d, exp_idx[n % 8], ((n % 8) == 7));
        end
        n++;
      end else if (n == 8) begin
        gap++;
      end
      tick();
    end
    checks++; if (n != 16) begin errors++; $display("FAIL ovf_count: got %0d transfers want 16", n); end
    checks++; if (gap != 2) begin errors++; $display("FAIL ovf_gap: got %0d idle cycles want 2", gap); end
    repeat (4) tick();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL ovf_dropped: valid got %b want 0", OUT_VALID); end
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", OVERFLOW); end
  endtask

  task automatic test_reset_mid();
    OUT_READY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      DV = 1'b1; DATA_IN = 16'h0040 + 16'(k);
      tick();
    end
    DV = 1'b0;
    RST_N = 1'b0;
    #2;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", OUT_VALID); end
    checks++; if (OUT_LAST !== 1'b0) begin errors++; $display("FAIL rmid_last: got %b want 0", OUT_LAST); end
    checks++; if (OUT_DATA !== 16'h0000) begin errors++; $display("FAIL rmid_data: got %h want 0000", OUT_DATA); end
    checks++; if (OUT_INDEX !== 3'd0) begin errors++; $display("FAIL rmid_index: got %0d want 0", OUT_INDEX); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL rmid_overflow: got %b want 0", OVERFLOW); end
    tick();
    RST_N = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      DV = 1'b1; DATA_IN = 16'h0050 + 16'(k);
      tick();
    end
    DV = 1'b0;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rmid_lat0: valid got %b want 0", OUT_VALID); end
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h0050 + 16'(exp_idx[k]) || OUT_INDEX !== exp_idx[k] || OUT_LAST !== (k == 7)) begin
        errors++;
        $display("FAIL rmid_word%0d: got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b",
                 k, OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, 16'h0050 + 16'(exp_idx[k]), exp_idx[k], (k == 7));
      end
      tick();
    end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rmid_after: valid got %b want 0", OUT_VALID); end
  endtask

  initial begin
`ifdef SFB_BITREV_EN
    exp_idx = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
    exp_idx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_frame_buffer.md
SAMPLE_FRAME_BUFFER -- requirements
Module: sample_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, log2 of frame length N (N = 2^ADDR_W).
REQ-003 SHALL have port CLK  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port DV  input  1  one-cycle strobe from the ADC SPI stage, sample present.
REQ-006 SHALL have port DATA_IN  input  DATA_W  ADC sample, valid when DV=1.
REQ-007 SHALL have port OUT_VALID  output  1  frame sample offered to the FFT stage.
REQ-008 SHALL have port OUT_READY  input  1  FFT stage accepts sample.
REQ-009 SHALL have port OUT_DATA  output  DATA_W  offered sample.
REQ-010 SHALL have port OUT_INDEX  output  ADDR_W  original in-frame sample index of OUT_DATA.
REQ-011 SHALL have port OUT_LAST  output  1  high with the final sample of a frame.
REQ-012 SHALL have port OVERFLOW  output  1  sticky, a sample was dropped.

Function
REQ-013 SHALL hold two banks of N words (ping-pong); each bank SHALL be EMPTY, FILLING, FULL or READING.
REQ-014 SHALL, on DV=1 with a FILLING bank, write DATA_IN at write pointer wp and increment wp, wrapping N-1 -> 0.
REQ-015 SHALL, on the write at wp=N-1, mark that bank FULL and make the other bank FILLING in the same cycle if that bank is EMPTY.
REQ-016 SHALL, when no bank is FILLING, discard DV samples, set OVERFLOW=1, and resume at wp=0 in the first bank to become EMPTY; partial frames SHALL never be emitted.
REQ-017 SHALL use a read FSM R_IDLE -> R_FETCH -> R_STREAM -> R_IDLE; R_IDLE leaves when a bank is FULL (oldest first), marking it READING.
REQ-018 SHALL account 1-cycle synchronous RAM read latency: OUT_VALID rises exactly 2 cycles after the cycle the bank became FULL when the FSM was idle.
REQ-019 SHALL hold OUT_DATA, OUT_INDEX and OUT_LAST stable while OUT_VALID=1 and OUT_READY=0; a transfer occurs only when both are 1.
REQ-020 SHALL sustain one transfer per cycle while OUT_READY=1 (prefetch/skid register, no bubbles within a frame).
REQ-021 SHALL, on the OUT_LAST transfer, mark the bank EMPTY; it SHALL be writable on the next cycle, and OUT_VALID SHALL drop unless the other bank is FULL (then 2-cycle gap per REQ-018).
REQ-022 SHALL, when DV arrives in the same cycle a bank is released and no bank is FILLING, drop that sample (release takes effect next cycle).
REQ-023 SHALL never read a FILLING bank and never write a READING or FULL bank.

Reset
REQ-024 SHALL, on RST_N=0 at any time, clear wp, read pointer, FSM to R_IDLE, both banks EMPTY with bank 0 FILLING, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, OUT_INDEX=0, OVERFLOW=0.
REQ-025 SHALL NOT clear RAM contents on reset; any in-progress frame is abandoned.

Configuration
REQ-026 SHALL, with SFB_BITREV_EN defined, read frame positions k=0..N-1 from address bitrev(k) so output is in radix-2 DIT input order; OUT_INDEX = bitrev(k).
REQ-027 SHALL, without SFB_BITREV_EN, read in natural order; OUT_INDEX = k.

Structure
REQ-028 SHALL take DATA_W/ADDR_W defaults, the bank-state encoding and a bitrev function from shared package fft_pkg.
REQ-029 SHALL instantiate one sub-module sample_ram: simple dual-port, 2*N x DATA_W, registered read, mappable to SB_RAM40_4K blocks.

Verification (ADDR_W=3, N=8)
REQ-030 SHALL check: 8 DV strobes with 0x0000..0x0007, OUT_READY=1 -> OUT_VALID 2 cycles after 8th DV, 8 back-to-back transfers 0..7, OUT_LAST on 0x0007.
REQ-031 SHALL check: same stimulus with SFB_BITREV_EN -> OUT_DATA order 0,4,2,6,1,5,3,7, OUT_INDEX equal to data.
REQ-032 SHALL check: OUT_READY toggled 1/0 every cycle -> outputs stable in stall cycles, no loss or duplication.
REQ-033 SHALL check: 24 DV strobes with OUT_READY=0 -> samples 16..23 dropped, OVERFLOW=1; after OUT_READY=1 frames 0..7 then 8..15 emitted.
REQ-034 SHALL check: RST_N pulsed low after 5 DVs -> all outputs reset-valued; next 8 DVs form a complete frame starting at OUT_INDEX 0.
